// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll sequencer.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SHOW = 2'd2
  } state_e;

  localparam logic [2:0] FACE_BLANK = 3'd0;
  localparam logic [2:0] FACE_MIN   = 3'd1;
  localparam logic [2:0] FACE_MAX   = 3'd6;

  // ((face-1) + 1 + ran) mod 6, plus 1; the sum is at most 9, so one subtract suffices.
  function automatic logic [2:0] next_face(input logic [2:0] face, input logic [1:0] ran);
    logic [3:0] sum;
    sum = {1'b0, face} + {2'b00, ran};
    if (sum >= {1'b0, FACE_MAX}) begin
      sum = sum - {1'b0, FACE_MAX};
    end
    return sum[2:0] + FACE_MIN;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, level debouncer and single-cycle press detect for a raw push-button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d, deb_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/dice_roll_sequencer.sv
// Debounced push-button starts a tumbling roll that slows each step, holds the face, then blanks.
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 1024,
  parameter int unsigned ROLL_STEPS      = 12,
  parameter int unsigned HOLD_TICKS      = 64
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Button,
  input  logic [1:0] Ran,
  output logic [2:0] DiceValue,
  output logic       Rolling,
  output logic       Done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned HW = $clog2(HOLD_TICKS) + 1;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    step_q, step_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [2:0]    face_q, face_d;
  logic          rolling_q, done_q;
  logic          press, tick, enter, step_now;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (Clock),
    .rst_n (nReset),
    .button(Button),
    .press (press)
  );

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign step_now = tick && (wait_cnt_q == step_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (press) state_d = ROLL;
      ROLL: if (step_now && (step_q == 4'(ROLL_STEPS - 1))) state_d = SHOW;
      SHOW: begin
        // A re-roll press beats hold expiry in the same cycle.
        if (press) begin
          state_d = ROLL;
        end else if (tick && (hold_q == HW'(HOLD_TICKS - 1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter = (state_d != state_q);

  always_comb begin
    presc_d    = (enter || tick) ? '0 : presc_q + PW'(1);
    face_d     = face_q;
    step_d     = step_q;
    wait_cnt_d = wait_cnt_q;
    hold_d     = hold_q;

    if (state_q == ROLL && tick) begin
      if (step_now) begin
        face_d     = next_face(face_q, Ran);
        step_d     = step_q + 4'd1;
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end else if (state_q == SHOW && tick) begin
      hold_d = hold_q + HW'(1);
    end

    // Entry actions run after stepping so the final face step survives ROLL -> SHOW.
    if (enter) begin
      unique case (state_d)
        ROLL: begin
          face_d     = FACE_MIN;
          step_d     = '0;
          wait_cnt_d = '0;
        end
        SHOW:    hold_d = '0;
        default: face_d = FACE_BLANK;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      hold_q     <= '0;
      step_q     <= '0;
      wait_cnt_q <= '0;
      face_q     <= FACE_BLANK;
      rolling_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      hold_q     <= hold_d;
      step_q     <= step_d;
      wait_cnt_q <= wait_cnt_d;
      face_q     <= face_d;
      rolling_q  <= (state_d == ROLL);
      done_q     <= (state_q == ROLL) && (state_d == SHOW);
    end
  end

  assign DiceValue = face_q;
  assign Rolling   = rolling_q;
  assign Done      = done_q;

endmodule
